// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the non-restoring divider controller.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// Clearable up-counter that saturates at WIDTH; last_o flags the final step.
module div_iter_cnt
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/div_ctrl.sv
// Sequencing FSM for a WIDTH-step non-restoring divider: load, iterate,
// one remainder fix-up cycle, then hold the result until it is consumed.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       divisor_zero_i,
  input  logic                       rem_neg_i,
  output logic                       load_o,
  output logic                       step_o,
  output logic                       fix_o,
  output logic [cnt_w(WIDTH)-1:0]    iter_cnt_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       dz_o,
  output logic                       busy_o,
  output div_state_e                 state_o
);

  localparam int CW = cnt_w(WIDTH);

  div_state_e state_q, state_d;
  logic       dz_q;
  logic       accept;
  logic       last_step;
  logic [CW-1:0] cnt;

  // Handshakes: a transfer happens only in a cycle where valid and ready are
  // both high. in_ready_o depends only on state and reset (never on
  // in_valid_i); out_valid_o, once raised, stays high with stable dz_o until
  // out_ready_i is seen with it.
  assign accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dz_q <= divisor_zero_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    load_o      = 1'b0;
    step_o      = 1'b0;
    fix_o       = 1'b0;
    out_valid_o = 1'b0;
    if (!reset_i) begin
      case (state_q)
        IDLE: begin
          in_ready_o = 1'b1;
          load_o     = in_valid_i;
          if (in_valid_i) begin
            state_d = divisor_zero_i ? DONE : ITER;
          end
        end
        ITER: begin
          step_o = 1'b1;
          if (last_step) begin
            state_d = FIX;
          end
        end
        FIX: begin
          fix_o   = rem_neg_i;
          state_d = DONE;
        end
        DONE: begin
          out_valid_o = 1'b1;
          if (out_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  div_iter_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (accept),
    .inc_i   (step_o),
    .cnt_o   (cnt),
    .last_o  (last_step)
  );

  assign iter_cnt_o = cnt;
  assign dz_o       = dz_q & out_valid_o;
  assign busy_o     = (state_q != IDLE);
  assign state_o    = state_q;

endmodule
